// File: rtl/reg_writeback_arbiter.sv
// Merges ALU results (priority, 1-cycle) and FIFO-buffered load results (>=2 cycles) onto the register-file write port.
// Backpressure: load_ready drops while the load FIFO is full; ALU results are never stalled; writes to x0 are discarded.
module reg_writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_rd,
    input  logic [DATA_W-1:0] load_data,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_index,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] query_idx1,
    input  logic [ADDR_W-1:0] query_idx2,
    output logic              pending1,
    output logic              pending2,
    output logic [CNT_W-1:0]  conflict_cnt
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;
    localparam logic [CNT_FW-1:0] DEPTH_C = CNT_FW'(FIFO_DEPTH);

    logic [ADDR_W-1:0] mem_rd_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_rd_d   [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0] count_q, count_d;

    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_index_q, write_index_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

    logic alu_take;
    logic fifo_empty;
    logic push;
    logic pop;

    // Ready is derived from the registered count only, so a pop this cycle never admits an extra load.
    assign load_ready = (count_q < DEPTH_C);

    always_comb begin
        alu_take   = alu_valid && (alu_rd != '0);
        fifo_empty = (count_q == '0);
        pop        = !alu_take && !fifo_empty;
        push       = load_valid && load_ready && (load_rd != '0);

        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        if (push) begin
            mem_rd_d[wr_ptr_q]   = load_rd;
            mem_data_d[wr_ptr_q] = load_data;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_FW'(push) - CNT_FW'(pop);

        conflict_cnt_d = conflict_cnt_q;
        if (alu_take && !fifo_empty && (conflict_cnt_q != '1)) begin
            conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
        end

        reg_write_d   = 1'b0;
        write_index_d = write_index_q;
        write_data_d  = write_data_q;
        if (alu_take) begin
            reg_write_d   = 1'b1;
            write_index_d = alu_rd;
            write_data_d  = alu_data;
        end else if (pop) begin
            reg_write_d   = 1'b1;
            write_index_d = mem_rd_q[rd_ptr_q];
            write_data_d  = mem_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_rd_q[i]   <= '0;
                mem_data_q[i] <= '0;
            end
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            reg_write_q    <= 1'b0;
            write_index_q  <= '0;
            write_data_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            mem_rd_q       <= mem_rd_d;
            mem_data_q     <= mem_data_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            reg_write_q    <= reg_write_d;
            write_index_q  <= write_index_d;
            write_data_q   <= write_data_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign reg_write    = reg_write_q;
    assign write_index  = write_index_q;
    assign write_data   = write_data_q;
    assign conflict_cnt = conflict_cnt_q;

    // Scan only the occupied slots, walking forward from the read pointer.
    logic             fifo_hit1;
    logic             fifo_hit2;
    logic [PTR_W-1:0] slot;

    always_comb begin
        fifo_hit1 = 1'b0;
        fifo_hit2 = 1'b0;
        slot      = '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            slot = rd_ptr_q + PTR_W'(k);
            if (CNT_FW'(k) < count_q) begin
                if (mem_rd_q[slot] == query_idx1) fifo_hit1 = 1'b1;
                if (mem_rd_q[slot] == query_idx2) fifo_hit2 = 1'b1;
            end
        end
    end

    assign pending1 = (query_idx1 != '0) &&
                      (fifo_hit1 || (reg_write_q && (write_index_q == query_idx1)));
    assign pending2 = (query_idx2 != '0) &&
                      (fifo_hit2 || (reg_write_q && (write_index_q == query_idx2)));

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed scenarios plus random traffic, checked against a queue-based model of the writeback rules.
module tb_reg_writeback_arbiter;
    logic        clk = 1'b0;
    logic        nRST;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        load_valid;
    logic        load_ready;
    logic [4:0]  load_rd;
    logic [31:0] load_data;
    logic        reg_write;
    logic [4:0]  write_index;
    logic [31:0] write_data;
    logic [4:0]  query_idx1;
    logic [4:0]  query_idx2;
    logic        pending1;
    logic        pending2;
    logic [15:0] conflict_cnt;

    reg_writeback_arbiter dut (
        .clk(clk), .nRST(nRST),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_rd(load_rd), .load_data(load_data),
        .reg_write(reg_write), .write_index(write_index), .write_data(write_data),
        .query_idx1(query_idx1), .query_idx2(query_idx2),
        .pending1(pending1), .pending2(pending2),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    bit          m_we;
    logic [4:0]  m_idx;
    logic [31:0] m_data;
    int          m_cnt;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_pend(input logic [4:0] idx);
        if (idx == 5'd0) return 1'b0;
        if (m_we && m_idx == idx) return 1'b1;
        foreach (q[i]) if (q[i].rd == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_we   = 1'b0;
        m_idx  = '0;
        m_data = '0;
        m_cnt  = 0;
    endtask

    task automatic set_in(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                          input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid  = av;
        alu_rd     = ard;
        alu_data   = ad;
        load_valid = lv;
        load_rd    = lrd;
        load_data  = ld;
    endtask

    // Inputs are already driven; check combinational outputs, advance model and DUT one edge, check registers.
    task automatic cycle();
        ent_t e;
        bit   ready;
        #1;
        check("pending1", pending1, m_pend(query_idx1));
        check("pending2", pending2, m_pend(query_idx2));
        ready = (q.size() < 4);
        check("load_ready", load_ready, ready);
        if (alu_valid && alu_rd != 5'd0) begin
            if (q.size() > 0 && m_cnt < 16'hFFFF) m_cnt++;
            m_we   = 1'b1;
            m_idx  = alu_rd;
            m_data = alu_data;
        end else if (q.size() > 0) begin
            e      = q.pop_front();
            m_we   = 1'b1;
            m_idx  = e.rd;
            m_data = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (load_valid && ready && load_rd != 5'd0) begin
            e.rd   = load_rd;
            e.data = load_data;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        check("reg_write", reg_write, m_we);
        check("write_index", write_index, m_idx);
        check("write_data", write_data, m_data);
        check("conflict_cnt", conflict_cnt, m_cnt);
        check("x0_never_written", reg_write && write_index == 5'd0, 1'b0);
    endtask

    initial begin
        nRST = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        query_idx1 = '0;
        query_idx2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_reg_write", reg_write, 0);
        check("rst_write_index", write_index, 0);
        check("rst_write_data", write_data, 0);
        check("rst_conflict", conflict_cnt, 0);
        check("rst_load_ready", load_ready, 1);
        nRST = 1'b1;

        // ALU-only write lands one cycle later, then the port goes idle.
        set_in(1, 5, 32'h1234, 0, 0, 0);
        cycle();
        check("t1_we", reg_write, 1);
        check("t1_idx", write_index, 5);
        check("t1_data", write_data, 32'h1234);
        set_in(0, 0, 0, 0, 0, 0);
        cycle();
        check("t1_idle", reg_write, 0);

        // Writes to x0 from either source vanish.
        set_in(1, 0, 32'hFFFF, 1, 0, 32'hFFFF);
        cycle();
        check("t2_we", reg_write, 0);
        check("t2_ready", load_ready, 1);
        set_in(0, 0, 0, 0, 0, 0);
        cycle();
        check("t2_we_after", reg_write, 0);

        // A buffered load yields to three ALU writes, then drains.
        set_in(0, 0, 0, 1, 3, 32'hAA);
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 7, 32'h700 + i, 0, 0, 0);
            cycle();
        end
        check("t3_conflicts", conflict_cnt, 3);
        set_in(0, 0, 0, 0, 0, 0);
        cycle();
        check("t3_load_idx", write_index, 3);
        check("t3_load_data", write_data, 32'hAA);

        // Fill the FIFO behind continuous ALU traffic; the fifth load must wait.
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("t4_full_ready", load_ready, 0);
            set_in(1, 5'(1 + i), 32'hA0 + i, 1, 5'(10 + i), 32'hB0 + i);
            cycle();
        end
        set_in(1, 2, 32'hC0, 1, 14, 32'hB4);
        cycle();
        check("t4_still_full", load_ready, 0);
        set_in(0, 0, 0, 1, 14, 32'hB4);
        cycle();
        for (int i = 0; i < 8; i++) begin
            set_in(0, 0, 0, 0, 0, 0);
            cycle();
        end
        check("t4_drained", q.size() == 0 && reg_write == 1'b0, 1);

        // Pending tracks the entry through the FIFO and the write stage.
        query_idx1 = 9;
        query_idx2 = 0;
        set_in(0, 0, 0, 1, 9, 32'h99);
        cycle();
        check("t5_fifo_p1", pending1, 1);
        check("t5_fifo_p2", pending2, 0);
        set_in(0, 0, 0, 0, 0, 0);
        cycle();
        check("t5_wb_p1", pending1, 1);
        cycle();
        check("t5_clear_p1", pending1, 0);

        // Reset mid-operation flushes three buffered loads.
        for (int i = 0; i < 3; i++) begin
            set_in(1, 4, 32'h400, 1, 5'(20 + i), 32'hD0 + i);
            cycle();
        end
        set_in(0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        #1;
        check("t6_we", reg_write, 0);
        check("t6_idx", write_index, 0);
        check("t6_data", write_data, 0);
        check("t6_cnt", conflict_cnt, 0);
        check("t6_ready", load_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        nRST = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        // Random traffic over a small index range so hits and x0 traffic are frequent.
        for (int i = 0; i < 2000; i++) begin
            set_in($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
            query_idx1 = 5'($urandom_range(0, 7));
            query_idx2 = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
